// File: rtl/alu_result_writeback_if.sv
// Bundle of the ALU-side result handshake and the register-file write port
// for the vector result writeback stage.
interface alu_result_writeback_if #(
  parameter int LANES  = 16,
  parameter int LANE_W = 32,
  parameter int ADDR_W = 2
);
  logic                      in_valid;
  logic                      in_ready;
  logic [2*LANES*LANE_W-1:0] in_result;
  logic [ADDR_W-1:0]         in_rd;
  logic                      wr_en;
  logic                      wr_ready;
  logic [ADDR_W-1:0]         wr_addr;
  logic [LANES*LANE_W-1:0]   wr_data;
  logic                      busy;
  logic                      done;

  // Producer side: ALU results in, register-file acceptance in.
  modport master (
    output in_valid, in_result, in_rd, wr_ready,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done
  );

  // Writeback stage side.
  modport slave (
    input  in_valid, in_result, in_rd, wr_ready,
    output in_ready, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/alu_result_writeback.sv
// Vector ALU writeback stage: captures one 16x64-bit result and writes it to
// the single-port vector register file as two beats, the low 32-bit halves
// of every lane to rd and the high halves to rd+1 (address wraps).
module alu_result_writeback #(
  parameter int LANES  = 16,
  parameter int LANE_W = 32,
  parameter int ADDR_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_result_writeback_if.slave bus
);
  localparam int RES_W = 2 * LANES * LANE_W;
  localparam int DAT_W = LANES * LANE_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [RES_W-1:0]  res_q, res_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic              done_q, done_d;

  logic [DAT_W-1:0]  lo_s, hi_s;
  logic              in_ready_s;
  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [DAT_W-1:0]  wr_data_s;

  // Split every captured 64-bit lane into its raw low and high words.
  always_comb begin
    lo_s = '0;
    hi_s = '0;
    for (int i = 0; i < LANES; i++) begin
      lo_s[i*LANE_W +: LANE_W] = res_q[i*2*LANE_W +: LANE_W];
      hi_s[i*LANE_W +: LANE_W] = res_q[i*2*LANE_W + LANE_W +: LANE_W];
    end
  end

  // Next-state: capture in IDLE, advance a beat on each accepted write.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    rd_d    = rd_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = WR_LO;
          res_d   = bus.in_result;
          rd_d    = bus.in_rd;
        end else begin
          state_d = IDLE;
        end
      end
      WR_LO: begin
        if (bus.wr_ready) begin
          state_d = WR_HI;
        end else begin
          state_d = WR_LO;
        end
      end
      WR_HI: begin
        if (bus.wr_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = WR_HI;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, captured operands and the done pulse; reset abandons any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      rd_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
    end
  end

  // Write port decodes straight from state so it drops with reset; idle bus is all-zero.
  always_comb begin
    in_ready_s = 1'b0;
    wr_en_s    = 1'b0;
    wr_addr_s  = '0;
    wr_data_s  = '0;
    case (state_q)
      IDLE: begin
        in_ready_s = 1'b1;
      end
      WR_LO: begin
        wr_en_s   = 1'b1;
        wr_addr_s = rd_q;
        wr_data_s = lo_s;
      end
      WR_HI: begin
        wr_en_s   = 1'b1;
        wr_addr_s = rd_q + ADDR_W'(1'b1);
        wr_data_s = hi_s;
      end
      default: begin
        in_ready_s = 1'b0;
      end
    endcase
  end

  assign bus.in_ready = in_ready_s;
  assign bus.wr_en    = wr_en_s;
  assign bus.wr_addr  = wr_addr_s;
  assign bus.wr_data  = wr_data_s;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
endmodule

// File: tb/tb_alu_result_writeback.sv
// Self-checking bench for alu_result_writeback: directed scenarios with
// literal expectations plus a randomized run compared every cycle against a
// queue-of-pending-writes reference model.
module tb_alu_result_writeback;
  localparam int LANES  = 16;
  localparam int LANE_W = 32;
  localparam int ADDR_W = 2;
  localparam int RES_W  = 2 * LANES * LANE_W;
  localparam int DAT_W  = LANES * LANE_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_result_writeback_if #(.LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W)) bus ();

  alu_result_writeback #(.LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DAT_W-1:0] act, input logic [DAT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference: a result becomes two pending register writes, low words then high words.
  function automatic logic [DAT_W-1:0] half(input logic [RES_W-1:0] r, input bit hi);
    logic [DAT_W-1:0] h;
    h = '0;
    for (int i = 0; i < LANES; i++) begin
      logic [63:0] lane;
      lane = r[i*64 +: 64];
      h[i*LANE_W +: LANE_W] = hi ? lane[63:32] : lane[31:0];
    end
    return h;
  endfunction

  function automatic logic [RES_W-1:0] rand_res();
    logic [RES_W-1:0] r;
    for (int i = 0; i < RES_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DAT_W-1:0]  data;
    bit                last;
  } beat_t;

  beat_t exp_q[$];
  bit    exp_done = 1'b0;
  bit    popped_last;

  // Model: accepts only when no writes are pending; pops a write per accepted beat.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_done = 1'b0;
    end else begin
      popped_last = 1'b0;
      if (exp_q.size() == 0) begin
        if (bus.in_valid) begin
          exp_q.push_back('{addr: bus.in_rd, data: half(bus.in_result, 1'b0), last: 1'b0});
          exp_q.push_back('{addr: ADDR_W'((int'(bus.in_rd) + 1) % (1 << ADDR_W)),
                            data: half(bus.in_result, 1'b1), last: 1'b1});
        end
      end else if (bus.wr_ready) begin
        popped_last = exp_q[0].last;
        void'(exp_q.pop_front());
      end
      exp_done = popped_last;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    bit pend;
    pend = (exp_q.size() != 0);
    chk("in_ready", DAT_W'(bus.in_ready), DAT_W'(!pend));
    chk("busy",     DAT_W'(bus.busy),     DAT_W'(pend));
    chk("wr_en",    DAT_W'(bus.wr_en),    DAT_W'(pend));
    chk("wr_addr",  DAT_W'(bus.wr_addr),  pend ? DAT_W'(exp_q[0].addr) : '0);
    chk("wr_data",  bus.wr_data,          pend ? exp_q[0].data : '0);
    chk("done",     DAT_W'(bus.done),     DAT_W'(exp_done));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [RES_W-1:0]  ra, rb;
  logic [DAT_W-1:0]  lit;
  logic [ADDR_W-1:0] rda, rdb, nxt;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_result = '0;
    bus.in_rd     = '0;
    bus.wr_ready  = 1'b0;

    // Reset state
    #3;
    chk("rst_in_ready", DAT_W'(bus.in_ready), DAT_W'(1'b1));
    chk("rst_wr_en",    DAT_W'(bus.wr_en),    DAT_W'(1'b0));
    chk("rst_wr_addr",  DAT_W'(bus.wr_addr),  '0);
    chk("rst_wr_data",  bus.wr_data,          '0);
    chk("rst_busy",     DAT_W'(bus.busy),     DAT_W'(1'b0));
    chk("rst_done",     DAT_W'(bus.done),     DAT_W'(1'b0));
    #9 rst_n = 1'b1;

    // Reset mid-operation in WR_LO
    step();
    bus.in_result = rand_res(); bus.in_rd = 2'd1; bus.in_valid = 1'b1; bus.wr_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstlo_wr_en",    DAT_W'(bus.wr_en),    DAT_W'(1'b0));
    chk("rstlo_busy",     DAT_W'(bus.busy),     DAT_W'(1'b0));
    chk("rstlo_in_ready", DAT_W'(bus.in_ready), DAT_W'(1'b1));
    #2 rst_n = 1'b1;
    step(); #1;
    chk("rstlo_no_done", DAT_W'(bus.done), DAT_W'(1'b0));

    // Reset mid-operation in WR_HI
    bus.in_valid = 1'b1; bus.wr_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    bus.wr_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rsthi_wr_en",    DAT_W'(bus.wr_en),    DAT_W'(1'b0));
    chk("rsthi_busy",     DAT_W'(bus.busy),     DAT_W'(1'b0));
    chk("rsthi_in_ready", DAT_W'(bus.in_ready), DAT_W'(1'b1));
    #2 rst_n = 1'b1;
    step(); #1;
    chk("rsthi_no_done", DAT_W'(bus.done), DAT_W'(1'b0));

    // Basic writeback: low halves 0x1000_0000+i, high halves zero
    ra = '0;
    lit = '0;
    for (int i = 0; i < LANES; i++) begin
      ra[i*64 +: 64] = {32'h0000_0000, 32'h1000_0000 + 32'(i)};
      lit[i*32 +: 32] = 32'h1000_0000 + 32'(i);
    end
    bus.in_result = ra; bus.in_rd = 2'd0; bus.in_valid = 1'b1; bus.wr_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("basic_lo_addr", DAT_W'(bus.wr_addr), DAT_W'(2'd0));
    chk("basic_lo_data", bus.wr_data, lit);
    chk("model_lo_pin",  half(ra, 1'b0), lit);
    step(); #1;
    chk("basic_hi_addr", DAT_W'(bus.wr_addr), DAT_W'(2'd1));
    chk("basic_hi_data", bus.wr_data, '0);
    step(); #1;
    chk("basic_done",    DAT_W'(bus.done),  DAT_W'(1'b1));
    chk("basic_idle_en", DAT_W'(bus.wr_en), DAT_W'(1'b0));
    step(); #1;
    chk("basic_done_1cy", DAT_W'(bus.done), DAT_W'(1'b0));

    // Negative product split into raw words, rd=2
    ra = '0;
    ra[63:0] = 64'hFFFF_FFFF_FFFF_FFFA;
    bus.in_result = ra; bus.in_rd = 2'd2; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("neg_lo_addr", DAT_W'(bus.wr_addr), DAT_W'(2'd2));
    chk("neg_lo_data", bus.wr_data, DAT_W'(32'hFFFF_FFFA));
    step(); #1;
    chk("neg_hi_addr", DAT_W'(bus.wr_addr), DAT_W'(2'd3));
    chk("neg_hi_data", bus.wr_data, DAT_W'(32'hFFFF_FFFF));
    chk("model_hi_pin", half(ra, 1'b1), DAT_W'(32'hFFFF_FFFF));
    step(); step();

    // Wrap (rd=3) with a stalled low beat
    ra = rand_res();
    bus.in_result = ra; bus.in_rd = 2'd3; bus.in_valid = 1'b1; bus.wr_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("stall_addr",     DAT_W'(bus.wr_addr),  DAT_W'(2'd3));
      chk("stall_data",     bus.wr_data,          half(ra, 1'b0));
      chk("stall_in_ready", DAT_W'(bus.in_ready), DAT_W'(1'b0));
      step();
    end
    bus.wr_ready = 1'b1;
    step(); #1;
    chk("wrap_hi_addr", DAT_W'(bus.wr_addr), DAT_W'(2'd0));
    chk("wrap_hi_data", bus.wr_data, half(ra, 1'b1));
    step(); step();

    // Back-to-back with in_valid held high
    ra = rand_res(); rb = rand_res();
    rda = 2'($urandom_range(0, 3)); rdb = 2'($urandom_range(0, 3));
    bus.in_result = ra; bus.in_rd = rda; bus.in_valid = 1'b1;
    step();
    bus.in_result = rb; bus.in_rd = rdb;
    #1;
    chk("b2b_alo_addr", DAT_W'(bus.wr_addr), DAT_W'(rda));
    chk("b2b_alo_data", bus.wr_data, half(ra, 1'b0));
    step(); #1;
    nxt = rda + 2'd1;
    chk("b2b_ahi_addr", DAT_W'(bus.wr_addr), DAT_W'(nxt));
    chk("b2b_ahi_data", bus.wr_data, half(ra, 1'b1));
    step(); #1;
    chk("b2b_done",     DAT_W'(bus.done),     DAT_W'(1'b1));
    chk("b2b_in_ready", DAT_W'(bus.in_ready), DAT_W'(1'b1));
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("b2b_blo_addr", DAT_W'(bus.wr_addr), DAT_W'(rdb));
    chk("b2b_blo_data", bus.wr_data, half(rb, 1'b0));
    step(); #1;
    nxt = rdb + 2'd1;
    chk("b2b_bhi_addr", DAT_W'(bus.wr_addr), DAT_W'(nxt));
    chk("b2b_bhi_data", bus.wr_data, half(rb, 1'b1));
    step(); step();

    // Operand change after accept
    ra = rand_res();
    bus.in_result = ra; bus.in_rd = 2'd1; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0; bus.in_result = ~ra; bus.in_rd = 2'd2;
    #1;
    chk("hold_lo_data", bus.wr_data, half(ra, 1'b0));
    step(); #1;
    chk("hold_hi_data", bus.wr_data, half(ra, 1'b1));
    step(); step();

    // Randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 3000; c++) begin
      bus.in_valid  = ($urandom_range(0, 1) == 1);
      bus.wr_ready  = ($urandom_range(0, 9) < 6);
      bus.in_result = rand_res();
      bus.in_rd     = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
